// File: rtl/accel_frame_pkg.sv
// Shared types and helpers for the accelerometer frame transmit scheduler.
package accel_frame_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

   // Data byte d of a packed sample: word d/2, high byte first.
   function automatic logic [7:0] byte_select(input logic [63:0] shadow, input logic [2:0] idx);
      logic [5:0] off;
      off = {idx[2:1], ~idx[0], 3'b000};
      return shadow[off +: 8];
   endfunction

   // Bytes per frame: sync + two per word + optional checksum.
   function automatic logic [3:0] frame_len(input int unsigned num_words, input logic chk_en);
      return 4'(2 * num_words + 1 + (chk_en ? 1 : 0));
   endfunction

endpackage

// File: rtl/accel_tx_watchdog.sv
// Per-byte completion watchdog; fully removed when TIMEOUT_CYCLES is 0.
module accel_tx_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 20000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   generate
      if (TIMEOUT_CYCLES == 0) begin : g_off
         logic unused_inputs;
         assign unused_inputs = ^{clk, reset, clear, enable};
         assign expire        = 1'b0;
      end else begin : g_on
         localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
         localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

         logic [CW-1:0] cnt_q, cnt_d;

         // Count enabled cycles, holding at the limit.
         always_comb begin
            cnt_d = cnt_q;
            if (clear) begin
               cnt_d = '0;
            end else if (enable && (cnt_q != LIMIT)) begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         // Counter register.
         always_ff @(posedge clk) begin
            if (reset) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end

         assign expire = enable && (cnt_q == LIMIT);
      end
   endgenerate

endmodule

// File: rtl/accel_frame_tx_sched.sv
// Frames multi-word accelerometer samples into UART byte streams:
// sync byte, each word MSB-first, optional XOR checksum.
// Checksum byte is compiled in when ACCEL_FRAME_CHECKSUM_EN is defined.
module accel_frame_tx_sched
   import accel_frame_pkg::*;
#(
   parameter int unsigned NUM_WORDS      = 3,
   parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
   parameter int unsigned TIMEOUT_CYCLES = 20000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [16*NUM_WORDS-1:0] sample_data,
   input  logic                   sample_valid,
   output logic                   sample_ready,
   output logic [7:0]             tx_byte,
   output logic                   tx_start,
   input  logic                   tx_done,
   output logic                   busy,
   output logic                   frame_done,
   output logic                   timeout_err,
   output logic [7:0]             overrun_cnt
);

`ifdef ACCEL_FRAME_CHECKSUM_EN
   localparam logic       CHK_EN     = 1'b1;
   localparam logic [3:0] DATA_BYTES = 4'(2 * NUM_WORDS);
`else
   localparam logic       CHK_EN     = 1'b0;
`endif
   localparam logic [3:0] LAST_IDX = frame_len(NUM_WORDS, CHK_EN) - 4'd1;

   state_e                 state_q, state_d;
   logic [16*NUM_WORDS-1:0] shadow_q, shadow_d;
   logic [3:0]             idx_q, idx_d;
   logic [7:0]             tx_byte_q, tx_byte_d;
   logic                   timeout_err_q, timeout_err_d;
   logic [7:0]             overrun_q, overrun_d;
   logic                   wd_expire;
   logic [63:0]            shadow_ext;
   logic [7:0]             next_byte;

   assign shadow_ext = 64'(shadow_q);

`ifdef ACCEL_FRAME_CHECKSUM_EN
   logic [7:0] chk;

   // XOR of every data byte of the latched sample.
   always_comb begin
      chk = '0;
      for (int unsigned i = 0; i < 2 * NUM_WORDS; i++) begin
         chk = chk ^ byte_select(shadow_ext, 3'(i));
      end
   end
`endif

   // Byte at index idx_q+1; frame index k>=1 carries data byte k-1.
   always_comb begin
      next_byte = byte_select(shadow_ext, idx_q[2:0]);
`ifdef ACCEL_FRAME_CHECKSUM_EN
      if (idx_q == DATA_BYTES) begin
         next_byte = chk;
      end
`endif
   end

   // Frame sequencing, byte register loading, error and overrun tracking.
   always_comb begin
      state_d       = state_q;
      shadow_d      = shadow_q;
      idx_d         = idx_q;
      tx_byte_d     = tx_byte_q;
      timeout_err_d = timeout_err_q;
      overrun_d     = overrun_q;
      case (state_q)
         ST_IDLE: begin
            if (sample_valid) begin
               shadow_d  = sample_data;
               idx_d     = '0;
               tx_byte_d = SYNC_BYTE;
               state_d   = ST_SEND;
            end
         end
         ST_SEND: state_d = ST_WAIT;
         ST_WAIT: begin
            if (tx_done) begin
               if (idx_q == LAST_IDX) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d     = idx_q + 4'd1;
                  tx_byte_d = next_byte;
                  state_d   = ST_SEND;
               end
            end else if (wd_expire) begin
               timeout_err_d = 1'b1;
               state_d       = ST_IDLE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (sample_valid && (state_q != ST_IDLE) && (overrun_q != 8'hFF)) begin
         overrun_d = overrun_q + 8'd1;
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         shadow_q      <= '0;
         idx_q         <= '0;
         tx_byte_q     <= 8'h00;
         timeout_err_q <= 1'b0;
         overrun_q     <= 8'h00;
      end else begin
         state_q       <= state_d;
         shadow_q      <= shadow_d;
         idx_q         <= idx_d;
         tx_byte_q     <= tx_byte_d;
         timeout_err_q <= timeout_err_d;
         overrun_q     <= overrun_d;
      end
   end

   accel_tx_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk   (clk),
      .reset (reset),
      .clear (state_q == ST_SEND),
      .enable(state_q == ST_WAIT),
      .expire(wd_expire)
   );

   assign sample_ready = (state_q == ST_IDLE);
   assign busy         = (state_q != ST_IDLE);
   assign tx_start     = (state_q == ST_SEND);
   assign frame_done   = (state_q == ST_DONE);
   assign tx_byte      = tx_byte_q;
   assign timeout_err  = timeout_err_q;
   assign overrun_cnt  = overrun_q;

endmodule

// File: tb/tb_accel_frame_tx_sched.sv
// Self-checking bench for accel_frame_tx_sched with a UART responder model.
// Honours ACCEL_FRAME_CHECKSUM_EN in its expected frames.
module tb_accel_frame_tx_sched;

   localparam int NW = 3;
   localparam int TO = 50;
`ifdef ACCEL_FRAME_CHECKSUM_EN
   localparam int CHK_ON = 1;
`else
   localparam int CHK_ON = 0;
`endif
   localparam int FLEN = 2 * NW + 1 + CHK_ON;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [47:0] sample_data = '0;
   logic        sample_valid = 1'b0;
   logic        sample_ready;
   logic [7:0]  tx_byte;
   logic        tx_start;
   logic        tx_done = 1'b0;
   logic        busy;
   logic        frame_done;
   logic        timeout_err;
   logic [7:0]  overrun_cnt;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [7:0]  obs_q[$];
   logic [7:0]  exp_q[$];
   int          resp_delay = 10;
   int          starts_seen = 0;
   int          mute_limit = 2147483647;
   bit          abort_flag = 1'b0;
   int          exp_ovr = 0;
   int          exp_terr = 0;

   accel_frame_tx_sched #(
      .NUM_WORDS     (NW),
      .SYNC_BYTE     (8'hA5),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .sample_data (sample_data),
      .sample_valid(sample_valid),
      .sample_ready(sample_ready),
      .tx_byte     (tx_byte),
      .tx_start    (tx_start),
      .tx_done     (tx_done),
      .busy        (busy),
      .frame_done  (frame_done),
      .timeout_err (timeout_err),
      .overrun_cnt (overrun_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [47:0] rand48();
      return 48'({$urandom(), $urandom()});
   endfunction

   // Expected byte stream: sync, each word high byte first, XOR of data bytes.
   task automatic build_frame(input logic [47:0] s);
      logic [15:0] word;
      logic [7:0]  x;
      exp_q.delete();
      exp_q.push_back(8'hA5);
      x = 8'h00;
      for (int w = 0; w < NW; w++) begin
         word = s[16*w +: 16];
         exp_q.push_back(word[15:8]);
         exp_q.push_back(word[7:0]);
         x = x ^ word[15:8] ^ word[7:0];
      end
      if (CHK_ON == 1) exp_q.push_back(x);
   endtask

   task automatic compare_bytes(input string tag, input int count);
      check_value({tag, "_nbytes"}, obs_q.size(), count);
      for (int i = 0; i < count && i < obs_q.size(); i++) begin
         check_value($sformatf("%s_byte%0d", tag, i), obs_q[i], exp_q[i]);
      end
      obs_q.delete();
   endtask

   // UART responder: records every started byte and answers tx_done resp_delay cycles later.
   initial begin
      int         cd;
      bit         pending;
      logic [7:0] held;
      cd = 0;
      pending = 1'b0;
      held = 8'h00;
      forever begin
         @(negedge clk);
         tx_done = 1'b0;
         if (pending) begin
            cd--;
            if (cd == 0) begin
               pending = 1'b0;
               tx_done = 1'b1;
               if (!abort_flag) check_value("tx_byte_stable", tx_byte, held);
            end
         end
         if (tx_start === 1'b1) begin
            obs_q.push_back(tx_byte);
            starts_seen++;
            held = tx_byte;
            if (starts_seen <= mute_limit) begin
               pending = 1'b1;
               cd = resp_delay;
            end
         end
      end
   end

   // One full frame starting at the current negedge; with chain=1 the next sample
   // is offered in the cycle of the last tx_done and held until accepted.
   task automatic run_frame(input logic [47:0] s, input int d, input int ovr, input bit chain,
                            input logic [47:0] nxt, input string tag);
      int n;
      int fd_count;
      n = FLEN * (d + 1);
      fd_count = 0;
      resp_delay = d;
      build_frame(s);
      sample_valid = 1'b1;
      sample_data = s;
      for (int c = 1; c <= n + 2; c++) begin
         @(negedge clk);
         if (frame_done === 1'b1) fd_count++;
         if (c == 1) begin
            check_value({tag, "_start_lat"}, tx_start, 1);
            check_value({tag, "_sync"}, tx_byte, 8'hA5);
         end
         sample_valid = (c >= 2) && (c <= 1 + ovr);
         sample_data = rand48();
         if (chain && c >= n) begin
            sample_valid = 1'b1;
            sample_data = nxt;
         end
         if (c == n) check_value({tag, "_fd_early"}, frame_done, 0);
         if (c == n + 1) begin
            check_value({tag, "_fd"}, frame_done, 1);
            check_value({tag, "_ready_in_done"}, sample_ready, 0);
         end
         if (c == n + 2) begin
            check_value({tag, "_ready_after"}, sample_ready, 1);
            check_value({tag, "_busy_after"}, busy, 0);
         end
      end
      exp_ovr = exp_ovr + ovr + (chain ? 2 : 0);
      if (exp_ovr > 255) exp_ovr = 255;
      check_value({tag, "_fd_count"}, fd_count, 1);
      check_value({tag, "_overrun"}, overrun_cnt, exp_ovr);
      check_value({tag, "_terr"}, timeout_err, exp_terr);
      compare_bytes(tag, FLEN);
   endtask

   // Responder acknowledges two bytes, then stays silent on the third.
   task automatic run_timeout(input logic [47:0] s, input int d);
      int sc;
      int fd_count;
      fd_count = 0;
      resp_delay = d;
      mute_limit = starts_seen + 2;
      build_frame(s);
      sample_valid = 1'b1;
      sample_data = s;
      sc = 1 + 2 * (d + 1);
      for (int c = 1; c <= sc + TO + 2; c++) begin
         @(negedge clk);
         if (frame_done === 1'b1) fd_count++;
         sample_valid = 1'b0;
         if (c == sc + TO + 1) begin
            check_value("to_terr_before", timeout_err, 0);
            check_value("to_busy_before", busy, 1);
         end
         if (c == sc + TO + 2) begin
            check_value("to_terr", timeout_err, 1);
            check_value("to_busy", busy, 0);
            check_value("to_ready", sample_ready, 1);
         end
      end
      exp_terr = 1;
      mute_limit = 2147483647;
      check_value("to_no_fd", fd_count, 0);
      compare_bytes("to", 3);
   endtask

   // Reset while the fourth byte waits for completion.
   task automatic run_reset_abort(input logic [47:0] s);
      int base;
      resp_delay = 10;
      build_frame(s);
      sample_valid = 1'b1;
      sample_data = s;
      for (int c = 1; c <= 1 + 3 * 11 + 3; c++) begin
         @(negedge clk);
         sample_valid = 1'b0;
      end
      abort_flag = 1'b1;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_ovr = 0;
      exp_terr = 0;
      check_value("rst_busy", busy, 0);
      check_value("rst_tx_start", tx_start, 0);
      check_value("rst_tx_byte", tx_byte, 8'h00);
      check_value("rst_ready", sample_ready, 1);
      check_value("rst_terr", timeout_err, 0);
      check_value("rst_overrun", overrun_cnt, 0);
      base = starts_seen;
      repeat (15) @(negedge clk);
      check_value("rst_no_start", starts_seen - base, 0);
      check_value("rst_late_done_busy", busy, 0);
      compare_bytes("rst_partial", 4);
      abort_flag = 1'b0;
   endtask

   initial begin
      logic [47:0] cur;
      logic [47:0] nxt;
      bit          chain;

      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_value("reset_busy", busy, 0);
      check_value("reset_ready", sample_ready, 1);
      check_value("reset_tx_start", tx_start, 0);
      check_value("reset_tx_byte", tx_byte, 8'h00);
      check_value("reset_frame_done", frame_done, 0);
      check_value("reset_terr", timeout_err, 0);
      check_value("reset_overrun", overrun_cnt, 0);
      reset = 1'b0;
      @(negedge clk);

      run_frame({16'h00FF, 16'hABCD, 16'h1234}, 10, 0, 1'b0, '0, "directed");

      run_frame(rand48(), 10, 5, 1'b0, '0, "ovr5");
      run_frame(rand48(), 4, 0, 1'b0, '0, "after_ovr");

      cur = rand48();
      nxt = rand48();
      run_frame(cur, 3, 0, 1'b1, nxt, "b2b_a");
      run_frame(nxt, 1, 0, 1'b0, '0, "b2b_b");

      cur = rand48();
      for (int k = 0; k < 6; k++) begin
         nxt = rand48();
         chain = (k < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
         run_frame(cur, int'($urandom_range(1, 12)), int'($urandom_range(0, 5)), chain, nxt,
                   $sformatf("rnd%0d", k));
         cur = nxt;
      end

      run_frame(rand48(), 45, 260, 1'b0, '0, "ovr_sat");

      run_frame(rand48(), TO + 1, 0, 1'b0, '0, "wd_edge");

      run_timeout(rand48(), 5);
      run_frame(rand48(), 6, 0, 1'b0, '0, "post_to");

      run_reset_abort(rand48());
      run_frame(rand48(), 7, 0, 1'b0, '0, "post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/accel_frame_tx_sched.md
# accel_frame_tx_sched

Transmit scheduler that owns the byte-wide UART transmitter and sequences multi-word accelerometer samples into framed byte streams. It accepts one packed sample of NUM_WORDS 16-bit words and emits a sync byte, then each word MSB-first, then an optional checksum. Each byte is issued to the UART with a one-cycle start pulse and completion handshake. It sits between the SPI accelerometer read path and the UART byte transmitter, and replaces ad-hoc Tx_Count sequencing.

## Interface
Parameters:
- NUM_WORDS, 3: 16-bit words per frame (legal 1..4).
- SYNC_BYTE, 8'hA5: first byte of every frame.
- TIMEOUT_CYCLES, 20000: maximum cycles waiting for tx_done per byte; 0 disables the watchdog.

Ports (one clock; reset is synchronous and active-high):
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high.
- sample_data, input, 16*NUM_WORDS: word0 in bits [15:0], word k in bits [16k+15:16k].
- sample_valid, input, 1: sample offered.
- sample_ready, output, 1: high only in IDLE; a transfer occurs when sample_valid and sample_ready are both high.
- tx_byte, output, 8: byte presented to the UART; stable from tx_start until tx_done.
- tx_start, output, 1: one-cycle enable pulse to the UART.
- tx_done, input, 1: one-cycle byte-complete pulse from the UART.
- busy, output, 1: high whenever state is not IDLE.
- frame_done, output, 1: one-cycle pulse after the last byte completes.
- timeout_err, output, 1: sticky; cleared only by reset.
- overrun_cnt, output, 8: saturating count of dropped samples.

## Operation
- States are IDLE, SEND, WAIT and DONE. All outputs come from registers or decodes of the state register.
- IDLE: on transfer, latch sample_data into a shadow register, set byte index = 0, and go to SEND.
- SEND: tx_start = 1 and tx_byte = byte[index]; go to WAIT and clear the watchdog. A tx_done seen in SEND is ignored.
- WAIT:
  - tx_done and index = last: go to DONE.
  - tx_done otherwise: index++ and go to SEND.
  - Watchdog reaches TIMEOUT_CYCLES: set timeout_err, abandon the frame, go to IDLE with no frame_done.
- DONE: frame_done = 1, then go to IDLE.
- Byte order: SYNC_BYTE, w0[15:8], w0[7:0], w1[15:8], … , then CHK when enabled.
- Frame length: 1 + 2*NUM_WORDS bytes, plus 1 with checksum. Index width is 4 bits.
- Overrun: sample_valid high while busy increments overrun_cnt by 1 per cycle it is high, saturating at 8'hFF. The sample is dropped and the shadow register is unchanged.
- A tx_done while in IDLE or DONE is ignored.
- Reset values: state IDLE, tx_start 0, tx_byte 8'h00, frame_done 0, timeout_err 0, overrun_cnt 0, shadow register 0. busy = 0 and sample_ready = 1 follow from state IDLE.
- Reset mid-frame: abort immediately, no further tx_start. A UART byte already in flight completes, and its tx_done is ignored.

## Timing
- Transfer in cycle 0 gives tx_start = SYNC_BYTE issue in cycle 1.
- tx_done in cycle n (WAIT) gives the next tx_start in cycle n+1, so there is 1 idle cycle between UART bytes.
- Last tx_done in cycle n gives frame_done in cycle n+1; sample_ready is high in cycle n+2.
- Watchdog: counts cycles in WAIT. A timeout is taken in the cycle the count equals TIMEOUT_CYCLES, and tx_done in that same cycle wins. Counter width is $clog2(TIMEOUT_CYCLES+1).

## Configuration
- ACCEL_FRAME_CHECKSUM_EN defined: append CHK = XOR of all 2*NUM_WORDS data bytes (sync byte excluded). Frame length is 2*NUM_WORDS+2.
- Not defined: no checksum logic. Frame length is 2*NUM_WORDS+1 and the last byte is w[NUM_WORDS-1][7:0].

## Structure
- Package accel_frame_pkg holds:
  - the state enum (2-bit);
  - the default SYNC_BYTE;
  - a byte-select function (shadow, index) returning 8 bits;
  - a frame-length function of NUM_WORDS and checksum enable.
- One sub-module, accel_tx_watchdog: a counter with clear/enable inputs and an expire output, compiled away when TIMEOUT_CYCLES = 0.

## Test plan
- NUM_WORDS=3, checksum on, sample 0x1234/0xABCD/0x00FF, UART responder tx_done 10 cycles after each start → bytes A5,12,34,AB,CD,00,FF,BF; exactly 8 tx_start pulses; one frame_done.
- Same stimulus with the macro undefined → 7 bytes ending FF, no BF.
- sample_valid held for 5 cycles during a frame → overrun_cnt = 5. The next frame carries the next accepted sample, not a dropped one.
- TIMEOUT_CYCLES=50, responder silent after the 2nd byte → timeout_err = 1 in cycle 50 of WAIT, back to IDLE, no frame_done. A new sample then transmits normally with timeout_err still 1.
- Reset asserted during byte 4 → next cycle busy = 0 and tx_start = 0. A late tx_done is ignored, and the next frame starts with A5.
- Back-to-back frames with tx_done in the same cycle as the next sample_valid → no byte lost. Latency from transfer to tx_start is exactly 1 cycle.
